// File: rtl/hw_control_unit.sv
// Hardwired control unit for the accumulator CPU: decodes SC, R, IR opcode and
// datapath status into register/memory strobes, a bus-select code and ALU op.
module hw_control_unit #(
  parameter int SC_WIDTH   = 3,
  parameter bit MEM_WAIT   = 1'b1,
  parameter bit INT_ENABLE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             instruction,
  input  logic                   mem_ready,
  input  logic                   dr_zero,
  input  logic                   int_req,
  input  logic                   int_en,
  output logic [23:0]            reg_mem_ctrl,
  output logic [2:0]             bus_ctrl,
  output logic [1:0]             alu_op,
  output logic [2**SC_WIDTH-1:0] t,
  output logic                   int_ack,
  output logic                   halted,
  output logic                   sc_err
);

  localparam int T_W = 2**SC_WIDTH;
  localparam logic [SC_WIDTH-1:0] SC_MAX = '1;

  localparam int AR_LD  = 3;
  localparam int AR_INC = 4;
  localparam int AR_CLR = 5;
  localparam int PC_LD  = 6;
  localparam int PC_INC = 7;
  localparam int PC_CLR = 8;
  localparam int DR_LD  = 9;
  localparam int DR_INC = 10;
  localparam int AC_LD  = 12;
  localparam int IR_LD  = 15;
  localparam int TR_LD  = 18;
  localparam int MEM_RD = 21;
  localparam int MEM_WR = 22;

  localparam logic [23:0] MEM_MASK = (24'd1 << MEM_RD) | (24'd1 << MEM_WR);

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  logic [SC_WIDTH-1:0] sc_reg, sc_next;
  logic                r_reg, r_next;
  logic                halted_reg, halted_next;
  logic                sc_err_reg, sc_err_next;

  logic [T_W-1:0] t_dec;
  logic [7:0]     d;
  logic           ind;

  logic [23:0] raw_ctrl;
  logic [2:0]  raw_bus;
  logic [1:0]  raw_alu;
  logic        clear_step;
  logic        halt_step;
  logic        ack_step;
  logic        stall;

  assign ind = instruction[3];

  genvar gi;
  generate
    for (gi = 0; gi < T_W; gi++) begin : g_t_dec
      assign t_dec[gi] = (sc_reg == SC_WIDTH'(gi));
    end
    for (gi = 0; gi < 8; gi++) begin : g_op_dec
      assign d[gi] = (instruction[2:0] == 3'(gi));
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_reg     <= '0;
      r_reg      <= 1'b0;
      halted_reg <= 1'b0;
      sc_err_reg <= 1'b0;
    end else begin
      sc_reg     <= sc_next;
      r_reg      <= r_next;
      halted_reg <= halted_next;
      sc_err_reg <= sc_err_next;
    end
  end

  // Next-state: a stalled or halted step leaves every piece of state untouched
  always_comb begin
    sc_next     = sc_reg;
    r_next      = r_reg;
    halted_next = halted_reg;
    sc_err_next = sc_err_reg;
    if (!halted_reg && !stall) begin
      if (halt_step) begin
        halted_next = 1'b1;
      end else if (clear_step) begin
        sc_next = '0;
        if (r_reg)
          r_next = 1'b0;
        else if (INT_ENABLE && int_en && int_req)
          r_next = 1'b1;
      end else begin
        sc_next = sc_reg + SC_WIDTH'(1);
        if (sc_reg == SC_MAX)
          sc_err_next = 1'b1;
      end
    end
  end

  // Output decode
  always_comb begin
    raw_ctrl   = '0;
    raw_bus    = BUS_NONE;
    raw_alu    = 2'd0;
    clear_step = 1'b0;
    halt_step  = 1'b0;
    ack_step   = 1'b0;
    if (halted_reg) begin
      raw_bus = BUS_NONE;
    end else if (r_reg) begin
      if (t_dec[0]) begin
        raw_ctrl[AR_CLR] = 1'b1;
        raw_ctrl[TR_LD]  = 1'b1;
        raw_bus          = BUS_PC;
      end else if (t_dec[1]) begin
        raw_ctrl[MEM_WR] = 1'b1;
        raw_ctrl[PC_CLR] = 1'b1;
        raw_bus          = BUS_TR;
      end else if (t_dec[2]) begin
        raw_ctrl[PC_INC] = 1'b1;
        ack_step         = 1'b1;
        clear_step       = 1'b1;
      end
    end else begin
      if (t_dec[0]) begin
        raw_ctrl[AR_LD] = 1'b1;
        raw_bus         = BUS_PC;
      end else if (t_dec[1]) begin
        raw_ctrl[MEM_RD] = 1'b1;
        raw_ctrl[IR_LD]  = 1'b1;
        raw_ctrl[PC_INC] = 1'b1;
        raw_bus          = BUS_MEM;
      end else if (t_dec[2]) begin
        raw_ctrl[AR_LD] = 1'b1;
        raw_bus         = BUS_IR;
      end else if (t_dec[3]) begin
        if (d[7]) begin
          if (ind)
            clear_step = 1'b1;
          else
            halt_step = 1'b1;
        end else if (ind) begin
          raw_ctrl[MEM_RD] = 1'b1;
          raw_ctrl[AR_LD]  = 1'b1;
          raw_bus          = BUS_MEM;
        end
      end else if (t_dec[4]) begin
        if (d[0] || d[1] || d[2] || d[6]) begin
          raw_ctrl[MEM_RD] = 1'b1;
          raw_ctrl[DR_LD]  = 1'b1;
          raw_bus          = BUS_MEM;
        end else if (d[3]) begin
          raw_ctrl[MEM_WR] = 1'b1;
          raw_bus          = BUS_AC;
          clear_step       = 1'b1;
        end else if (d[4]) begin
          raw_ctrl[PC_LD] = 1'b1;
          raw_bus         = BUS_AR;
          clear_step      = 1'b1;
        end else if (d[5]) begin
          raw_ctrl[MEM_WR] = 1'b1;
          raw_ctrl[AR_INC] = 1'b1;
          raw_bus          = BUS_PC;
        end
      end else if (t_dec[5]) begin
        if (d[0] || d[1] || d[2]) begin
          raw_ctrl[AC_LD] = 1'b1;
          raw_alu         = d[2] ? 2'd2 : (d[1] ? 2'd1 : 2'd0);
          clear_step      = 1'b1;
        end else if (d[5]) begin
          raw_ctrl[PC_LD] = 1'b1;
          raw_bus         = BUS_AR;
          clear_step      = 1'b1;
        end else if (d[6]) begin
          raw_ctrl[DR_INC] = 1'b1;
        end
      end else if (t_dec[6]) begin
        if (d[6]) begin
          raw_ctrl[MEM_WR] = 1'b1;
          raw_ctrl[PC_INC] = dr_zero;
          raw_bus          = BUS_DR;
          clear_step       = 1'b1;
        end
      end
    end

    // A waiting memory step keeps its bus and read/write but drops every other strobe
    stall = MEM_WAIT && ((raw_ctrl & MEM_MASK) != '0) && !mem_ready;

    reg_mem_ctrl = '0;
    bus_ctrl     = BUS_NONE;
    alu_op       = 2'd0;
    int_ack      = 1'b0;
    if (rst_n) begin
      reg_mem_ctrl = stall ? (raw_ctrl & MEM_MASK) : raw_ctrl;
      bus_ctrl     = raw_bus;
      alu_op       = stall ? 2'd0 : raw_alu;
      int_ack      = INT_ENABLE && ack_step;
    end
  end

  assign t      = t_dec;
  assign halted = halted_reg;
  assign sc_err = sc_err_reg;

endmodule

// File: tb/tb_hw_control_unit.sv
// Directed bench for hw_control_unit: fetch/execute sequences, wait states,
// ISZ skip, interrupt cycle, halt and a wide-SC / no-wait build.
module tb_hw_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  instr;
  logic        mem_ready, dz, int_req, int_en;
  logic [23:0] ctrl;
  logic [2:0]  bus;
  logic [1:0]  alu;
  logic [7:0]  t;
  logic        ack, halted, err;

  logic        rst2_n;
  logic [3:0]  instr2;
  logic        mem_ready2, dz2, int_req2, int_en2;
  logic [23:0] ctrl2;
  logic [2:0]  bus2;
  logic [1:0]  alu2;
  logic [15:0] t2;
  logic        ack2, halted2, err2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hw_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instruction(instr), .mem_ready(mem_ready),
    .dr_zero(dz), .int_req(int_req), .int_en(int_en),
    .reg_mem_ctrl(ctrl), .bus_ctrl(bus), .alu_op(alu), .t(t),
    .int_ack(ack), .halted(halted), .sc_err(err)
  );

  hw_control_unit #(.SC_WIDTH(4), .MEM_WAIT(1'b0), .INT_ENABLE(1'b1)) dut_w (
    .clk(clk), .rst_n(rst2_n), .instruction(instr2), .mem_ready(mem_ready2),
    .dr_zero(dz2), .int_req(int_req2), .int_en(int_en2),
    .reg_mem_ctrl(ctrl2), .bus_ctrl(bus2), .alu_op(alu2), .t(t2),
    .int_ack(ack2), .halted(halted2), .sc_err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] et, input logic [23:0] ec,
                            input logic [2:0] eb, input logic ea);
    #1;
    check($sformatf("%s.t", tag), 32'(t), 32'(et));
    check($sformatf("%s.ctrl", tag), 32'(ctrl), 32'(ec));
    check($sformatf("%s.bus", tag), 32'(bus), 32'(eb));
    check($sformatf("%s.ack", tag), 32'(ack), 32'(ea));
  endtask

  // Checks T0..T2 of a normal fetch; leaves the bench in the T2 cycle
  task automatic fetch(input string tag);
    expect_out({tag, ".T0"}, 8'h01, 24'h000008, 3'd2, 1'b0);
    step();
    expect_out({tag, ".T1"}, 8'h02, 24'h208080, 3'd7, 1'b0);
    step();
    expect_out({tag, ".T2"}, 8'h04, 24'h000008, 3'd5, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] exp_c2 [7];
    exp_c2 = '{24'h000008, 24'h208080, 24'h000008, 24'h000000,
               24'h200200, 24'h000400, 24'h400080};

    rst_n = 1'b0; instr = 4'b0010; mem_ready = 1'b1; dz = 1'b0;
    int_req = 1'b0; int_en = 1'b0;
    rst2_n = 1'b0; instr2 = 4'b0110; mem_ready2 = 1'b0; dz2 = 1'b1;
    int_req2 = 1'b0; int_en2 = 1'b0;

    // Reset values, then LDA direct
    repeat (3) step();
    expect_out("rst", 8'h01, 24'h0, 3'd0, 1'b0);
    check("rst.alu", 32'(alu), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.sc_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    fetch("lda");
    step(); expect_out("lda.T3", 8'h08, 24'h0, 3'd0, 1'b0);
    step(); expect_out("lda.T4", 8'h10, 24'h200200, 3'd7, 1'b0);
    step(); expect_out("lda.T5", 8'h20, 24'h001000, 3'd0, 1'b0);
    check("lda.alu", 32'(alu), 32'd2);
    step(); expect_out("lda.next", 8'h01, 24'h000008, 3'd2, 1'b0);
    $display("txn lda direct done");

    // Indirect ADD, two wait cycles on the T3 indirect read
    instr = 4'b1001;
    fetch("add");
    step(); mem_ready = 1'b0;
    expect_out("add.T3w0", 8'h08, 24'h200000, 3'd7, 1'b0);
    step();
    expect_out("add.T3w1", 8'h08, 24'h200000, 3'd7, 1'b0);
    step(); mem_ready = 1'b1;
    expect_out("add.T3rdy", 8'h08, 24'h200008, 3'd7, 1'b0);
    step(); expect_out("add.T4", 8'h10, 24'h200200, 3'd7, 1'b0);
    step(); expect_out("add.T5", 8'h20, 24'h001000, 3'd0, 1'b0);
    check("add.alu", 32'(alu), 32'd1);
    step(); expect_out("add.next", 8'h01, 24'h000008, 3'd2, 1'b0);
    $display("txn add indirect with wait done");

    // ISZ, DR reaches zero (skip) then non-zero (no skip)
    instr = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      string tg;
      tg = (k == 0) ? "isz1" : "isz0";
      fetch(tg);
      step(); expect_out({tg, ".T3"}, 8'h08, 24'h0, 3'd0, 1'b0);
      step(); expect_out({tg, ".T4"}, 8'h10, 24'h200200, 3'd7, 1'b0);
      step(); expect_out({tg, ".T5"}, 8'h20, 24'h000400, 3'd0, 1'b0);
      step(); dz = (k == 0);
      expect_out({tg, ".T6"}, 8'h40, (k == 0) ? 24'h400080 : 24'h400000, 3'd3, 1'b0);
      step(); dz = 1'b0;
      expect_out({tg, ".next"}, 8'h01, 24'h000008, 3'd2, 1'b0);
      $display("txn %s done", tg);
    end

    // STA with a pending interrupt: R-cycle follows the clear step
    instr = 4'b0011; int_en = 1'b1; int_req = 1'b1;
    fetch("sta_i");
    step(); expect_out("sta_i.T3", 8'h08, 24'h0, 3'd0, 1'b0);
    step(); expect_out("sta_i.T4", 8'h10, 24'h400000, 3'd4, 1'b0);
    step(); int_req = 1'b0;
    expect_out("int.R0", 8'h01, 24'h040020, 3'd2, 1'b0);
    step(); expect_out("int.R1", 8'h02, 24'h400100, 3'd6, 1'b0);
    step(); expect_out("int.R2", 8'h04, 24'h000080, 3'd0, 1'b1);
    step(); expect_out("int.next", 8'h01, 24'h000008, 3'd2, 1'b0);
    $display("txn sta with interrupt done");

    // Same with IEN low: no interrupt cycle
    int_en = 1'b0; int_req = 1'b1;
    fetch("sta_n");
    step(); expect_out("sta_n.T3", 8'h08, 24'h0, 3'd0, 1'b0);
    step(); expect_out("sta_n.T4", 8'h10, 24'h400000, 3'd4, 1'b0);
    step(); expect_out("sta_n.next", 8'h01, 24'h000008, 3'd2, 1'b0);
    $display("txn sta without interrupt done");

    // HLT with an interrupt requested and enabled
    instr = 4'b0111; int_en = 1'b1;
    fetch("hlt");
    step(); expect_out("hlt.T3", 8'h08, 24'h0, 3'd0, 1'b0);
    check("hlt.T3.halted", 32'(halted), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(); expect_out($sformatf("hlt.idle%0d", k), 8'h08, 24'h0, 3'd0, 1'b0);
      check($sformatf("hlt.idle%0d.halted", k), 32'(halted), 32'd1);
    end
    rst_n = 1'b0;
    expect_out("hlt.rst", 8'h01, 24'h0, 3'd0, 1'b0);
    check("hlt.rst.halted", 32'(halted), 32'd0);
    check("main.sc_err", 32'(err), 32'd0);
    $display("txn halt done");

    // Wide SC, no wait states, mem_ready tied low: ISZ in 7 cycles
    step();
    check("w.rst.t", 32'(t2), 32'h1);
    check("w.rst.ctrl", 32'(ctrl2), 32'h0);
    rst2_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int exp_t;
      exp_t = 1 << i;
      if (i > 0) step(); else #1;
      check($sformatf("w.T%0d.t", i), 32'(t2), 32'(exp_t));
      check($sformatf("w.T%0d.ctrl", i), 32'(ctrl2), 32'(exp_c2[i]));
    end
    step();
    check("w.next.t", 32'(t2), 32'h1);
    check("w.sc_err", 32'(err2), 32'd0);
    $display("txn wide isz done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hw_control_unit.md
# hw_control_unit

Parametrised hardwired control unit for the accumulator CPU. It generates the `reg_mem_ctrl` strobe vector and the `bus_ctrl` bus-select code from a sequence counter, the IR opcode and datapath status. Compared with the previous unit, it adds an asynchronous reset, a configurable sequence-counter width, memory wait-state handling, branch/subroutine/skip instructions, halt, and an interrupt cycle. It sits between IR/datapath status and the register file, memory and bus multiplexer.

## Interface
- `SC_WIDTH`, 3: sequence counter width; must be ≥3. `t` is 2**SC_WIDTH wide.
- `MEM_WAIT`, 1: when 1, memory steps stall until `mem_ready`. When 0, `mem_ready` is ignored and treated as 1.
- `INT_ENABLE`, 1: when 1, the interrupt cycle exists. When 0, `int_req`/`int_en` are ignored and `int_ack`=0.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instruction` in 4: IR[15:12]. Bit 3 = I (indirect); bits [2:0] = opcode. Valid from T2 onward.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `dr_zero` in 1: DR == 0 (datapath comparator).
- `int_req` in 1: interrupt request, level.
- `int_en` in 1: interrupt enable (IEN), level.
- `reg_mem_ctrl` out 24: strobes, one bit per function:
  - AR load/inc/clr = 3/4/5
  - PC load/inc/clr = 6/7/8
  - DR load/inc/clr = 9/10/11
  - AC load/inc/clr = 12/13/14
  - IR load = 15
  - TR load/inc/clr = 18/19/20
  - mem read = 21, mem write = 22
  - bits 0,1,2,16,17,23 are always 0.
- `bus_ctrl` out 3: bus source. 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
- `alu_op` out 2: 0 AND, 1 ADD, 2 pass DR, 3 unused. Meaningful only when AC load is asserted.
- `t` out 2**SC_WIDTH: one-hot decode of the SC (T0 = bit 0).
- `int_ack` out 1: one-cycle pulse on the last step of the interrupt cycle.
- `halted` out 1: HLT executed.
- `sc_err` out 1: sticky flag, SC wrapped without a clear.

## Operation
- **State:** SC (SC_WIDTH bits), R (interrupt-cycle flag), halted, sc_err. All outputs are a combinational decode of this state plus the inputs.
- **Opcode decode** (`instruction[2:0]` → D0..D7):
  - D0 AND, D1 ADD, D2 LDA, D3 STA, D4 BUN, D5 BSA, D6 ISZ.
  - D7 with I=0 is HLT; D7 with I=1 is NOP.
- **Fetch, R=0:**
  - T0: AR←PC (bus 2, AR load).
  - T1: IR←M[AR], PC++ (bus 7, read, IR load, PC inc).
  - T2: AR←IR (bus 5, AR load).
  - T3: if I=1 and not D7, AR←M[AR] (bus 7, read, AR load). Otherwise there are no strobes; D7 finishes at T3 (NOP: SC clear; HLT: set halted).
- **Execute** (the step marked "clear" clears SC):
  - AND/ADD/LDA: T4 DR←M[AR] (bus 7, read, DR load); T5 AC load with `alu_op` 0/1/2, bus 0, clear.
  - STA: T4 M[AR]←AC (bus 4, write), clear.
  - BUN: T4 PC←AR (bus 1, PC load), clear.
  - BSA: T4 M[AR]←PC, AR++ (bus 2, write, AR inc); T5 PC←AR (bus 1, PC load), clear.
  - ISZ: T4 DR←M[AR]; T5 DR inc; T6 M[AR]←DR (bus 3, write), PC inc if `dr_zero`, clear.
- **Interrupt cycle, R=1:**
  - T0: AR clr, TR←PC (bus 2, TR load).
  - T1: M[AR]←TR (bus 6, write), PC clr.
  - T2: PC inc, R←0, `int_ack`=1, clear.
- **Interrupt entry:** R is set on the clear step of any instruction when INT_ENABLE=1, `int_en`=1 and `int_req`=1. It is never set by HLT.
- **Wait states:** in any step with mem read or write, while MEM_WAIT=1 and `mem_ready`=0:
  - SC holds.
  - `bus_ctrl` and the read/write bits stay asserted.
  - All load/inc/clr strobes for that step are forced to 0.
  - The step completes on the cycle with `mem_ready`=1.
- **Halt:** all strobes 0, `bus_ctrl`=0, SC frozen, `int_req` ignored. Only `rst_n` exits.
- **SC overflow:** SC at its maximum with no clear wraps to 0 and sets `sc_err`. This is unreachable with a legal decode; `sc_err` is cleared only by reset.

## Timing
- **Reset:** while `rst_n`=0:
  - SC=0, R=0, halted=0, sc_err=0.
  - `reg_mem_ctrl`=0, `bus_ctrl`=0, `alu_op`=0, `int_ack`=0, `t`=1.
  - The first rising edge after release executes T0, whose outputs are visible as soon as `rst_n` rises.
- **Reset mid-instruction:** takes effect immediately, abandoning any pending wait.
- **Cycle counts, zero wait:**
  - AND/ADD/LDA/BSA: 6 cycles.
  - STA/BUN: 5 cycles.
  - ISZ: 7 cycles.
  - NOP: 4 cycles.
  - Interrupt cycle: 3 cycles.
  - Indirect adds no cycles; the T3 slot is always present.
- **Sampling:** `dr_zero` is sampled at ISZ T6 (post-increment DR). `int_req` is sampled only on clear steps that actually complete (not during a wait).
- **Clear step:** SC returns to 0 on the next edge.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs 0, `t`=1. Release, with `instruction`=4'b0010 (LDA direct) and `mem_ready`=1 → `t` walks T0..T5; at T5 `reg_mem_ctrl[12]`=1 and `alu_op`=2; the next cycle is T0.
- **Indirect ADD with wait state:** `instruction`=4'b1001, `mem_ready` low for 2 cycles at T3 → SC holds at T3 for 3 cycles, bits 21 and `bus_ctrl`=7 held, bit 3 asserted only in the ready cycle; total 8 cycles.
- **ISZ skip:** `instruction`=4'b0110, `dr_zero`=1 at T6 → T6 asserts bits 22 and 7, `bus_ctrl`=3. Repeat with `dr_zero`=0 → bit 7 stays 0.
- **Interrupt:** `int_en`=1, `int_req`=1 during STA → after the STA T4 clear, three R-cycles follow with bus 2/6/0; `int_ack` pulses at the third; fetch resumes. Repeat with `int_en`=0 → no interrupt cycle.
- **Halt:** `instruction`=4'b0111 → `halted`=1 after T3; all strobes 0 indefinitely even with `int_req`=1; assert `rst_n`=0 → `halted`=0.
- **Parameters:** `SC_WIDTH`=4, `MEM_WAIT`=0, `mem_ready` tied 0 → ISZ completes in 7 cycles, `t` is 16 bits, `sc_err` stays 0.
